axi_byte_tx: RTL and testbench

// - Transmit end of the 8-bit valid/ready write channel that feeds the ALU byte FIFO (wdata/wvalid/wready).
// - Accepts one up-to-DATA_W-bit word per command and serialises it into BEAT_W-bit beats.
// - Each packet is an optional length header beat followed by data beats.
// - Sits between the ALU result/command source and the FIFO write port; honours FIFO backpressure.

---
 rtl/axi_alu_pkg.sv | 11 +
 rtl/axi_byte_tx_if.sv | 25 ++
 rtl/axi_byte_tx.sv | 149 ++++++++++++++
 tb/tb_axi_byte_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_alu_pkg.sv
// Shared types and constants for the ALU-to-FIFO byte transmit path.
package axi_alu_pkg;
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_HDR  = 2'd1,
        TX_DATA = 2'd2
    } tx_state_e;

    localparam logic [3:0] HDR_SYNC = 4'hA;
    localparam int         BEAT_W   = 8;
endpackage

// File: rtl/axi_byte_tx_if.sv
// Command input and valid/ready byte-beat output bundled for the byte transmitter.
interface axi_byte_tx_if #(
    parameter int DATA_W = 32
);
    import axi_alu_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic [3:0]        in_nbytes;
    logic              in_valid;
    logic              in_ready;
    logic [BEAT_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;

    modport master (
        input  in_data, in_nbytes, in_valid, tx_ready,
        output in_ready, tx_data, tx_valid, tx_last
    );

    modport slave (
        output in_data, in_nbytes, in_valid, tx_ready,
        input  in_ready, tx_data, tx_valid, tx_last
    );
endinterface

// File: rtl/axi_byte_tx.sv
// Serialises one command word into an optional length header beat plus byte beats
// on a valid/ready channel; all channel outputs come straight from flops.
module axi_byte_tx
    import axi_alu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MSB_FIRST = 0,
    parameter int HDR_EN    = 1
) (
    input  logic          clk,
    input  logic          reset,
    axi_byte_tx_if.master bus,
    output logic          busy,
    output logic [15:0]   stall_cnt
);
    localparam int         NBYTES   = DATA_W / 8;
    localparam logic [3:0] NBYTES_4 = 4'(NBYTES);

    tx_state_e         r_state;
    logic [DATA_W-1:0] r_shift;
    logic [3:0]        r_remain;
    logic [BEAT_W-1:0] r_tx_data;
    logic              r_tx_valid;
    logic              r_tx_last;
    logic              r_in_ready;
    logic [15:0]       r_stall_cnt;

    logic [3:0]        w_len;
    logic [3:0]        w_pad;
    logic [DATA_W-1:0] w_word;
    logic              w_accept;
    logic              w_beat_done;

    function automatic logic [BEAT_W-1:0] head_byte(input logic [DATA_W-1:0] w);
        if (MSB_FIRST != 0) begin
            return w[DATA_W-1 -: BEAT_W];
        end else begin
            return w[BEAT_W-1:0];
        end
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        if (MSB_FIRST != 0) begin
            return w << BEAT_W;
        end else begin
            return w >> BEAT_W;
        end
    endfunction

    // Clamp length; for MSB-first, left-align byte nbytes-1 so it leaves first
    always_comb begin
        if ((bus.in_nbytes == 4'd0) || (bus.in_nbytes > NBYTES_4)) begin
            w_len = NBYTES_4;
        end else begin
            w_len = bus.in_nbytes;
        end
        w_pad = NBYTES_4 - w_len;
        if (MSB_FIRST != 0) begin
            w_word = bus.in_data << {w_pad, 3'b000};
        end else begin
            w_word = bus.in_data;
        end
    end

    assign w_accept    = bus.in_valid && r_in_ready;
    assign w_beat_done = r_tx_valid && bus.tx_ready;

    // Packet FSM: r_tx_data always holds the beat currently offered, r_shift the rest
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= TX_IDLE;
            r_shift    <= '0;
            r_remain   <= 4'd0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_remain   <= w_len;
                        r_tx_valid <= 1'b1;
                        if (HDR_EN != 0) begin
                            r_state   <= TX_HDR;
                            r_shift   <= w_word;
                            r_tx_data <= {HDR_SYNC, w_len};
                            r_tx_last <= 1'b0;
                        end else begin
                            r_state   <= TX_DATA;
                            r_shift   <= shift_out(w_word);
                            r_tx_data <= head_byte(w_word);
                            r_tx_last <= (w_len == 4'd1);
                        end
                    end
                end
                TX_HDR: begin
                    if (w_beat_done) begin
                        r_state   <= TX_DATA;
                        r_shift   <= shift_out(r_shift);
                        r_tx_data <= head_byte(r_shift);
                        r_tx_last <= (r_remain == 4'd1);
                    end
                end
                TX_DATA: begin
                    if (w_beat_done) begin
                        if (r_remain == 4'd1) begin
                            r_state    <= TX_IDLE;
                            r_remain   <= 4'd0;
                            r_tx_data  <= '0;
                            r_tx_valid <= 1'b0;
                            r_tx_last  <= 1'b0;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_shift   <= shift_out(r_shift);
                            r_tx_data <= head_byte(r_shift);
                            r_remain  <= r_remain - 4'd1;
                            r_tx_last <= (r_remain == 4'd2);
                        end
                    end
                end
                default: begin
                    r_state    <= TX_IDLE;
                    r_tx_valid <= 1'b0;
                    r_tx_last  <= 1'b0;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    // Backpressure statistics, saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
        end else if (r_tx_valid && !bus.tx_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_last  = r_tx_last;
    assign busy         = (r_state != TX_IDLE);
    assign stall_cnt    = r_stall_cnt;
endmodule

// File: tb/tb_axi_byte_tx.sv
// Bench for axi_byte_tx: three configurations (LSB-first+hdr, MSB-first+hdr, LSB-first no hdr)
// checked against directed vectors and a queue-based packet model.
module tb_axi_byte_tx;
    logic clk;
    logic reset;

    logic [31:0] c_data  [3];
    logic [3:0]  c_nb    [3];
    logic        c_valid [3];
    logic        t_rdy   [3];
    logic [7:0]  m_data  [3];
    logic        m_valid [3];
    logic        m_last  [3];
    logic        m_inrdy [3];
    logic        m_busy  [3];
    logic [15:0] m_stall [3];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        axi_byte_tx_if #(.DATA_W(32)) bus ();
        assign bus.in_data   = c_data[g];
        assign bus.in_nbytes = c_nb[g];
        assign bus.in_valid  = c_valid[g];
        assign bus.tx_ready  = t_rdy[g];
        assign m_data[g]     = bus.tx_data;
        assign m_valid[g]    = bus.tx_valid;
        assign m_last[g]     = bus.tx_last;
        assign m_inrdy[g]    = bus.in_ready;

        axi_byte_tx #(
            .DATA_W   (32),
            .MSB_FIRST((g == 1) ? 1 : 0),
            .HDR_EN   ((g == 2) ? 0 : 1)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .bus      (bus.master),
            .busy     (m_busy[g]),
            .stall_cnt(m_stall[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beat list from the packet rules: header, then the low len bytes in order
    task automatic model(input int k, input logic [31:0] d, input logic [3:0] nb,
                         output logic [7:0] q[$]);
        int len;
        int idx;
        logic [7:0] b [$];
        len = ((nb == 4'd0) || (nb > 4'd4)) ? 4 : int'(nb);
        if (k != 2) b.push_back({4'hA, 4'(len)});
        for (int i = 0; i < len; i++) begin
            idx = (k == 1) ? (len - 1 - i) : i;
            b.push_back(8'((d >> (8 * idx)) & 32'hFF));
        end
        q = b;
    endtask

    // Present a command at a negedge; returns at the negedge where the first beat is offered
    task automatic send(input int k, input logic [31:0] d, input logic [3:0] nb, input bit hold);
        int cyc = 0;
        c_data[k]  = d;
        c_nb[k]    = nb;
        c_valid[k] = 1'b1;
        while (!m_inrdy[k] && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("accept_ready", m_inrdy[k], 1);
        @(negedge clk);
        if (!hold) c_valid[k] = 1'b0;
        chk("latency_valid", m_valid[k], 1);
        chk("busy_high", m_busy[k], 1);
        chk("in_ready_low", m_inrdy[k], 0);
    endtask

    // Drain a packet; mode 1 = random ready, otherwise ready high except a stall at beat stall_at
    task automatic collect(input int k, input logic [7:0] q[$], input int mode,
                           input int stall_at, input int stall_len);
        int idx = 0;
        int cyc = 0;
        int stalls = 0;
        logic r;
        logic pv = 1'b0;
        logic [7:0] pd = 8'h00;
        logic pl = 1'b0;
        while (idx < q.size() && cyc < 400) begin
            chk("valid_held", m_valid[k], 1);
            if (!m_valid[k]) break;
            if (pv) begin
                chk("stable_data", m_data[k], pd);
                chk("stable_last", m_last[k], pl);
            end
            if (mode == 1) begin
                r = 1'($urandom_range(0, 1));
            end else if (idx == stall_at && stalls < stall_len) begin
                r = 1'b0;
                stalls++;
            end else begin
                r = 1'b1;
            end
            t_rdy[k] = r;
            if (r) begin
                chk("beat", m_data[k], q[idx]);
                chk("last", m_last[k], (idx == q.size() - 1) ? 1 : 0);
                idx++;
                pv = 1'b0;
            end else begin
                pv = 1'b1;
                pd = m_data[k];
                pl = m_last[k];
            end
            @(negedge clk);
            cyc++;
        end
        t_rdy[k] = 1'b1;
        chk("beats_done", idx, q.size());
        chk("idle_valid", m_valid[k], 0);
        chk("in_ready_after", m_inrdy[k], 1);
    endtask

    typedef struct {
        int          k;
        logic [31:0] d;
        logic [3:0]  nb;
        int          n;
        logic [39:0] beats;
    } vec_t;

    vec_t        vt [8];
    logic [7:0]  q  [$];
    logic [7:0]  q2 [$];

    initial begin
        vt[0] = '{0, 32'h11223344, 4'd4,  5, 40'hA4_44_33_22_11};
        vt[1] = '{1, 32'hAABBCCDD, 4'd2,  3, 40'hA2_CC_DD_00_00};
        vt[2] = '{1, 32'hAABBCCDD, 4'd0,  5, 40'hA4_AA_BB_CC_DD};
        vt[3] = '{0, 32'h11223344, 4'd1,  2, 40'hA1_44_00_00_00};
        vt[4] = '{0, 32'h11223344, 4'd15, 5, 40'hA4_44_33_22_11};
        vt[5] = '{2, 32'hDEADBEEF, 4'd3,  3, 40'hEF_BE_AD_00_00};
        vt[6] = '{1, 32'h12345678, 4'd1,  2, 40'hA1_78_00_00_00};
        vt[7] = '{2, 32'hCAFEF00D, 4'd4,  4, 40'h0D_F0_FE_CA_00};

        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            c_data[k] = 32'd0; c_nb[k] = 4'd0; c_valid[k] = 1'b0; t_rdy[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", m_inrdy[k], 0);
            chk("rst_valid", m_valid[k], 0);
            chk("rst_last", m_last[k], 0);
            chk("rst_data", m_data[k], 0);
            chk("rst_busy", m_busy[k], 0);
            chk("rst_stall", m_stall[k], 0);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("post_rst_in_ready", m_inrdy[k], 1);

        // Directed vector table, ready always high
        for (int v = 0; v < 8; v++) begin
            q = {};
            for (int i = 0; i < vt[v].n; i++) begin
                logic [39:0] bb;
                bb = vt[v].beats;
                q.push_back(bb[39 - 8*i -: 8]);
            end
            send(vt[v].k, vt[v].d, vt[v].nb, 1'b0);
            collect(vt[v].k, q, 0, -1, 0);
        end
        chk("no_stall_yet", m_stall[0], 0);

        // Three stall cycles while 0x33 is offered
        q = {8'hA4, 8'h44, 8'h33, 8'h22, 8'h11};
        send(0, 32'h11223344, 4'd4, 1'b0);
        collect(0, q, 0, 2, 3);
        chk("stall_cnt_3", m_stall[0], 3);

        // Back-to-back with in_valid held high
        model(0, 32'h11223344, 4'd4, q);
        model(0, 32'h01020304, 4'd2, q2);
        send(0, 32'h11223344, 4'd4, 1'b1);
        collect(0, q, 0, -1, 0);
        c_data[0] = 32'h01020304;
        c_nb[0]   = 4'd2;
        @(negedge clk);
        c_valid[0] = 1'b0;
        chk("b2b_accept_valid", m_valid[0], 1);
        chk("b2b_in_ready_low", m_inrdy[0], 0);
        collect(0, q2, 0, -1, 0);

        // Reset after header and two data beats
        send(0, 32'h11223344, 4'd4, 1'b0);
        chk("mid_hdr", m_data[0], 8'hA4);
        @(negedge clk);
        chk("mid_b0", m_data[0], 8'h44);
        @(negedge clk);
        chk("mid_b1", m_data[0], 8'h33);
        @(negedge clk);
        chk("mid_b2", m_data[0], 8'h22);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", m_valid[0], 0);
        chk("mid_rst_busy", m_busy[0], 0);
        chk("mid_rst_stall", m_stall[0], 0);
        chk("mid_rst_last", m_last[0], 0);
        chk("mid_rst_in_ready", m_inrdy[0], 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_post_in_ready", m_inrdy[0], 1);
        chk("mid_post_valid", m_valid[0], 0);
        model(0, 32'h55667788, 4'd3, q);
        send(0, 32'h55667788, 4'd3, 1'b0);
        collect(0, q, 0, -1, 0);
        chk("sat_start", m_stall[0], 0);

        // Long backpressure on the header beat
        model(0, 32'h11223344, 4'd4, q);
        send(0, 32'h11223344, 4'd4, 1'b0);
        for (int i = 0; i < 65534; i++) begin
            t_rdy[0] = 1'b0;
            @(negedge clk);
        end
        chk("sat_fffe", m_stall[0], 16'hFFFE);
        for (int i = 0; i < 4466; i++) begin
            t_rdy[0] = 1'b0;
            @(negedge clk);
        end
        chk("sat_ffff", m_stall[0], 16'hFFFF);
        chk("sat_valid", m_valid[0], 1);
        chk("sat_hold_data", m_data[0], 8'hA4);
        collect(0, q, 0, -1, 0);
        chk("sat_stays", m_stall[0], 16'hFFFF);

        // Random commands and random backpressure against the model
        for (int n = 0; n < 60; n++) begin
            int k;
            logic [31:0] d;
            logic [3:0] nb;
            k  = int'($urandom_range(0, 2));
            d  = $urandom;
            nb = 4'($urandom_range(0, 15));
            model(k, d, nb, q);
            send(k, d, nb, 1'b0);
            collect(k, q, 1, -1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
